lsu_pipelined: RTL and testbench

Parametrised load/store unit for the next-generation RV pipeline. It replaces the fixed single-cycle, lane-0-only memory path with three additions:
- a valid/ready request interface from the execute stage;
- a variable-latency memory handshake with byte-lane steering and sign/zero extension;
- a bus timeout that returns an error response.
`busy` feeds the hazard unit as a stall source.

---
 rtl/lsu_pipelined.sv | 131 +++++++++++++
 tb/tb_lsu_pipelined.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lsu_pipelined.sv
// lsu_pipelined: valid/ready load/store unit with byte-lane steering, extension and bus timeout (optional LSU_MISALIGN_EN)
module lsu_pipelined #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic              store_q, store_d, err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, data_q, data_d, sh, ld_data;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [OW-1:0]     req_mask, amask, off;
  logic [NB-1:0]     strb_base;
  logic              legal, misal, tmo;
  assign legal = req_store ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11 || XLEN == 64))
                           : (req_funct3 != 3'b111 && ((req_funct3 != 3'b011 && req_funct3 != 3'b110) || XLEN == 64));
  assign req_mask = OW'((1 << req_funct3[1:0]) - 1);
`ifdef LSU_MISALIGN_EN
  assign misal = |(req_addr[OW-1:0] & req_mask);
`else
  assign misal = 1'b0;
`endif
  // Offsets below the access size are masked so an unaligned request never straddles lanes
  assign amask = OW'((1 << f3_q[1:0]) - 1);
  assign off   = addr_q[OW-1:0] & ~amask;
  assign sh    = mem_rdata >> {off, 3'b000};
  assign ld_data = f3_q == 3'b000 ? XLEN'($signed(sh[7:0]))  :
                   f3_q == 3'b001 ? XLEN'($signed(sh[15:0])) :
                   f3_q == 3'b010 ? XLEN'($signed(sh[31:0])) :
                   f3_q == 3'b100 ? XLEN'(sh[7:0])  :
                   f3_q == 3'b101 ? XLEN'(sh[15:0]) :
                   f3_q == 3'b110 ? XLEN'(sh[31:0]) : sh;
  assign strb_base = f3_q[1:0] == 2'd0 ? NB'(1) : f3_q[1:0] == 2'd1 ? NB'(3) :
                     f3_q[1:0] == 2'd2 ? NB'(4'hF) : '1;
  assign tmo = (TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign req_ready  = state_q == IDLE;
  assign busy       = !req_ready;
  assign mem_valid  = state_q == ACCESS;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rd    = (resp_valid && !err_q && !store_q) ? rd_q : 5'd0;
  assign resp_data  = resp_valid ? data_q : '0;
  assign mem_addr   = {addr_q[ADDR_W-1:OW], OW'(0)};
  assign mem_wstrb  = (mem_valid && store_q) ? strb_base << off : '0;
  assign mem_wdata  = f3_q[1:0] == 2'd0 ? {NB{wdata_q[7:0]}} :
                      f3_q[1:0] == 2'd1 ? {(NB/2){wdata_q[15:0]}} :
                      f3_q[1:0] == 2'd2 ? {(NB/4){wdata_q[31:0]}} : wdata_q;
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        store_d = req_store;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rd_d    = req_rd;
        err_d   = !legal || misal;
        data_d  = err_d ? XLEN'(req_addr) : '0;
        cnt_d   = '0;
        state_d = err_d ? RESP : ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_ready) begin
          data_d  = store_q ? '0 : ld_data;
          cnt_d   = '0;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          data_d  = XLEN'(addr_q);
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    store_q <= store_d;
    err_q   <= err_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    data_q  <= data_d;
    rd_q    <= rd_d;
  end
endmodule

// File: tb/tb_lsu_pipelined.sv
// tb_lsu_pipelined: directed checks of lsu_pipelined at XLEN=32, TIMEOUT_CYCLES=4
module tb_lsu_pipelined;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0, resp_rd;
  logic        resp_valid, resp_err, busy, mem_valid, mem_ready = 1'b0;
  logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  int tests = 0, failed = 0, n;

  lsu_pipelined #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid),
    .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic op(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                    input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew, input logic [31:0] ed);
    drive(st, f3, a, wd, rd);
    chk({tag, "_mem_valid"}, mem_valid, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_mem_addr"}, mem_addr, ea);
    chk({tag, "_wstrb"}, mem_wstrb, es);
    if (st) chk({tag, "_wdata"}, mem_wdata, ew);
    mem_ready = 1'b1; mem_rdata = rdat;
    @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_data"}, resp_data, ed);
    chk({tag, "_resp_rd"}, resp_rd, st ? 5'd0 : rd);
    chk({tag, "_mem_valid_off"}, mem_valid, 0);
  endtask

  task automatic ill(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
    drive(st, f3, a, 32'h0, 5'd9);
    chk({tag, "_no_mem"}, mem_valid, 0);
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_resp_err"}, resp_err, 1);
    chk({tag, "_resp_data"}, resp_data, a);
    chk({tag, "_resp_rd"}, resp_rd, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rd", resp_rd, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_wstrb", mem_wstrb, 0);

    op("sw",  1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 5'd3, 32'h104, 4'hF, 32'hDEADBEEF, 32'h0);
    op("lb",  0, 3'b000, 32'h103, 32'h0, 32'h80112233, 5'd5, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80);
    op("lbu", 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 5'd6, 32'h100, 4'h0, 32'h0, 32'h00000080);
    op("lhu", 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 5'd7, 32'h100, 4'h0, 32'h0, 32'h00008011);
    op("sh",  1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 5'd3, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
    op("sb",  1, 3'b000, 32'h101, 32'h1234565A, 32'h0, 5'd3, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0);
    op("lh_mask", 0, 3'b001, 32'h103, 32'h0, 32'h80112233, 5'd8, 32'h100, 4'h0, 32'h0, 32'hFFFF8011);
`ifdef LSU_MISALIGN_EN
    ill("lw_misal", 0, 3'b010, 32'h102);
`else
    op("lw_mask", 0, 3'b010, 32'h102, 32'h0, 32'h80112233, 5'd9, 32'h100, 4'h0, 32'h0, 32'h80112233);
`endif

    drive(0, 3'b010, 32'h200, 32'h0, 5'd7);
    n = 0;
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      if (mem_valid) n++;
      @(negedge clk);
    end
    chk("tmo_valid_cycles", n, 4);
    chk("tmo_resp_valid", resp_valid, 1);
    chk("tmo_resp_err", resp_err, 1);
    chk("tmo_resp_data", resp_data, 32'h200);
    chk("tmo_resp_rd", resp_rd, 0);

    drive(0, 3'b010, 32'h300, 32'h0, 5'd8);
    repeat (3) begin
      chk("late_mem_valid", mem_valid, 1);
      @(negedge clk);
    end
    chk("late_mem_valid4", mem_valid, 1);
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("late_resp_valid", resp_valid, 1);
    chk("late_resp_err", resp_err, 0);
    chk("late_resp_data", resp_data, 32'h11223344);
    chk("late_resp_rd", resp_rd, 8);

    drive(1, 3'b010, 32'h400, 32'h55, 5'd0);
    chk("rstmid_in_access", mem_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_mem_valid", mem_valid, 0);
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("rstmid_resp_valid2", resp_valid, 0);

    ill("lw_f3_011", 0, 3'b011, 32'h500);
    ill("ld_f3_111", 0, 3'b111, 32'h504);
    ill("st_f3_100", 1, 3'b100, 32'h508);
    ill("sd_xlen32", 1, 3'b011, 32'h50C);

    @(negedge clk);
    chk("end_idle", req_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
